// File: rtl/clock_pkg.sv
// Shared mode encoding and button bundle for the clock's front-panel,
// counter and display blocks.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'b00,
      MODE_SET_HOUR = 2'b01,
      MODE_SET_MIN  = 2'b10,
      MODE_SET_SEC  = 2'b11
   } mode_e;

   localparam int NUM_BTN = 3;

   // Bit order matches {btn_dw_n, btn_up_n, btn_mode_n} at the top level.
   typedef struct packed {
      logic dw;
      logic up;
      logic mode;
   } btn_t;

   function automatic mode_e next_mode(input mode_e m);
      return mode_e'(2'(m + 2'd1));
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchronizer, inversion to active-high, debounce and
// a registered one-cycle press event issued together with the level rise.
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DB_CYCLES) + 1;

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          act;

   assign act = ~sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b11;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn_n};
         press <= 1'b0;
         // Any cycle agreeing with the accepted level restarts the count.
         if (act != level) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
               level <= act;
               press <= act;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel controller: debounced buttons, RUN/SET mode FSM, inc/dec pulses
// with hold-to-repeat, count enable and field blink. TIME_SET_TIMEOUT_EN adds idle return to RUN.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int DB_CYCLES  = 1_000_000,
   parameter int RPT_DELAY  = 25_000_000,
   parameter int RPT_PERIOD = 10_000_000,
   parameter int BLINK_HALF = 12_500_000,
   parameter int TIMEOUT    = 500_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode_n,
   input  logic       btn_up_n,
   input  logic       btn_dw_n,
   output logic [1:0] select_mode,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       count_ena,
   output logic       blink_on
);
   localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int RW      = $clog2(RPT_MAX) + 1;
   localparam int BW      = $clog2(BLINK_HALF) + 1;

   logic [NUM_BTN-1:0] raw_n, lvl_v, ev_v;
   btn_t               lvl, ev;

   assign raw_n = {btn_dw_n, btn_up_n, btn_mode_n};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
      btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .btn_n (raw_n[g]),
         .level (lvl_v[g]),
         .press (ev_v[g])
      );
   end

   assign lvl = btn_t'(lvl_v);
   assign ev  = btn_t'(ev_v);

   mode_e         mode_q, mode_d;
   logic          inc_q, inc_d, dec_q, dec_d;
   logic          cena_q, cena_d, blink_q, blink_d;
   logic          rpt_act_q, rpt_act_d, rpt_dw_q, rpt_dw_d;
   logic          rpt_first_q, rpt_first_d;
   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_lim;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          fire_up, fire_dw, timeout;

`ifdef TIME_SET_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT) + 1;

   logic [TW-1:0] idle_q, idle_d;

   assign timeout = (mode_q != MODE_RUN) && (idle_q == TW'(TIMEOUT));

   // Any held or newly pressed button counts as activity.
   always_comb begin
      idle_d = idle_q;
      if (mode_d == MODE_RUN || (lvl | ev) != '0)
         idle_d = '0;
      else if (idle_q != TW'(TIMEOUT))
         idle_d = idle_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idle_q <= '0;
      else        idle_q <= idle_d;
   end
`else
   localparam int unused_timeout = TIMEOUT;
   logic unused_mode_lvl;

   assign timeout         = 1'b0;
   assign unused_mode_lvl = lvl.mode;
`endif

   assign rpt_lim = rpt_first_q ? RW'(RPT_DELAY - 1) : RW'(RPT_PERIOD - 1);

   always_comb begin
      mode_d      = mode_q;
      rpt_act_d   = rpt_act_q;
      rpt_dw_d    = rpt_dw_q;
      rpt_first_d = rpt_first_q;
      rpt_cnt_d   = rpt_cnt_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      fire_up     = 1'b0;
      fire_dw     = 1'b0;

      // Priority: timeout, mode, RUN hold-off, up+down conflict, new press, repeat.
      if (timeout) begin
         mode_d    = MODE_RUN;
         rpt_act_d = 1'b0;
      end else if (ev.mode) begin
         mode_d    = next_mode(mode_q);
         rpt_act_d = 1'b0;
      end else if (mode_q == MODE_RUN) begin
         rpt_act_d = 1'b0;
      end else if (lvl.up && lvl.dw) begin
         rpt_act_d = 1'b0;
      end else if (ev.up || ev.dw) begin
         fire_up     = ev.up;
         fire_dw     = ev.dw;
         rpt_act_d   = 1'b1;
         rpt_dw_d    = ev.dw;
         rpt_first_d = 1'b1;
         rpt_cnt_d   = '0;
      end else if (rpt_act_q) begin
         if (rpt_dw_q ? !lvl.dw : !lvl.up) begin
            rpt_act_d = 1'b0;
         end else if (rpt_cnt_q == rpt_lim) begin
            fire_up     = !rpt_dw_q;
            fire_dw     = rpt_dw_q;
            rpt_first_d = 1'b0;
            rpt_cnt_d   = '0;
         end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
         end
      end

      // An idle repeat engine always restarts from the long first delay.
      if (!rpt_act_d) begin
         rpt_cnt_d   = '0;
         rpt_first_d = 1'b1;
      end

      if (mode_d == MODE_RUN || mode_d != mode_q || fire_up || fire_dw) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
         blink_d     = !blink_q;
         blink_cnt_d = '0;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end

      inc_d  = fire_up;
      dec_d  = fire_dw;
      cena_d = (mode_d == MODE_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= MODE_RUN;
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         cena_q      <= 1'b1;
         blink_q     <= 1'b1;
         rpt_act_q   <= 1'b0;
         rpt_dw_q    <= 1'b0;
         rpt_first_q <= 1'b1;
         rpt_cnt_q   <= '0;
         blink_cnt_q <= '0;
      end else begin
         mode_q      <= mode_d;
         inc_q       <= inc_d;
         dec_q       <= dec_d;
         cena_q      <= cena_d;
         blink_q     <= blink_d;
         rpt_act_q   <= rpt_act_d;
         rpt_dw_q    <= rpt_dw_d;
         rpt_first_q <= rpt_first_d;
         rpt_cnt_q   <= rpt_cnt_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign select_mode = mode_q;
   assign inc_pulse   = inc_q;
   assign dec_pulse   = dec_q;
   assign count_ena   = cena_q;
   assign blink_on    = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected mode changes and pulses are
// queued with their cycle when buttons are driven, then matched on the outputs.
module tb_time_set_ctrl;
   localparam int DB  = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;
   localparam int BH  = 10;
   localparam int TO  = 100;
   localparam int LAT = DB + 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_mode_n = 1'b1;
   logic       btn_up_n = 1'b1;
   logic       btn_dw_n = 1'b1;
   logic [1:0] select_mode;
   logic       inc_pulse, dec_pulse, count_ena, blink_on;

   time_set_ctrl #(
      .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .BLINK_HALF(BH), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_mode_n(btn_mode_n), .btn_up_n(btn_up_n),
      .btn_dw_n(btn_dw_n), .select_mode(select_mode), .inc_pulse(inc_pulse),
      .dec_pulse(dec_pulse), .count_ena(count_ena), .blink_on(blink_on)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;   // 0 mode change, 1 inc, 2 dec
      int at;
      int val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails = 0;
   logic [1:0] exp_mode = 2'd0;
   logic       mon_en = 1'b0;
   logic [1:0] prev_mode = 2'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0d want %0d at cycle %0d", tag, got, want, cyc);
      end
   endtask

   task automatic push(input int kind, input int at, input int val);
      exp_t e;
      e.kind = kind; e.at = at; e.val = val;
      sb.push_back(e);
   endtask

   task automatic sb_pop(input string tag, input int kind, input logic [31:0] val, output int want_val);
      exp_t e;
      want_val = -1;
      chk({tag, "_expected"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_kind"}, kind, e.kind);
         chk({tag, "_cycle"}, cyc, e.at);
         chk({tag, "_val"}, val, e.val);
         want_val = e.val;
      end
   endtask

   always @(negedge clk) begin
      int wv;
      if (mon_en) begin
         if (select_mode != prev_mode) begin
            sb_pop("mode", 0, select_mode, wv);
            chk("count_ena", count_ena, wv == 0);
            prev_mode <= select_mode;
         end
         if (inc_pulse || dec_pulse) begin
            chk("pulse_excl", inc_pulse & dec_pulse, 0);
            chk("blink_on_pulse", blink_on, 1);
         end
         if (inc_pulse) sb_pop("inc", 1, 1, wv);
         if (dec_pulse) sb_pop("dec", 2, 1, wv);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         tick(1);
         k++;
      end
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic mode_press();
      exp_mode = exp_mode + 2'd1;
      push(0, cyc + LAT, exp_mode);
      btn_mode_n = 1'b0;
      tick(10);
      btn_mode_n = 1'b1;
      tick(10);
   endtask

   // Hold up (dir 1) or down (dir 2) for h cycles; pulses expected while the
   // debounced level is still high, i.e. up to h+DB+2 cycles after the press.
   task automatic hold(input int dir, input int h);
      int n, t;
      bit first;
      n = cyc; t = LAT; first = 1'b1;
      while (t <= h + DB + 2) begin
         push(dir, n + t, 1);
         t = t + (first ? RD : RP);
         first = 1'b0;
      end
      if (dir == 1) btn_up_n = 1'b0;
      else          btn_dw_n = 1'b0;
      tick(h);
      btn_up_n = 1'b1;
      btn_dw_n = 1'b1;
      tick(10);
   endtask

   initial begin
      int n, r, e;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      chk("rst_mode", select_mode, 0);
      chk("rst_count_ena", count_ena, 1);
      chk("rst_blink", blink_on, 1);
      chk("rst_inc", inc_pulse, 0);
      chk("rst_dec", dec_pulse, 0);
      mon_en = 1'b1;

      // Short bounce on mode must not be accepted.
      btn_mode_n = 1'b0;
      tick(3);
      btn_mode_n = 1'b1;
      tick(20);
      chk("bounce_mode", select_mode, 0);

      repeat (4) mode_press();
      drain(20);

      // SET_MIN: up held 60 cycles gives first pulse then repeats.
      repeat (2) mode_press();
      hold(1, 60);
      drain(40);
      chk("min_mode", select_mode, 2);

      // SET_HOUR: up held, down joins, up released, down still held.
      repeat (3) mode_press();
      n = cyc;
      push(1, n + LAT, 1);
      btn_up_n = 1'b0;
      tick(10);
      btn_dw_n = 1'b0;
      tick(30);
      btn_up_n = 1'b1;
      tick(30);
      btn_dw_n = 1'b1;
      tick(10);
      hold(2, 10);
      drain(20);

      // SET_SEC: mode pressed while up held cancels repeat.
      repeat (2) mode_press();
      n = cyc;
      push(1, n + LAT, 1);
      btn_up_n = 1'b0;
      tick(15);
      exp_mode = exp_mode + 2'd1;
      push(0, cyc + LAT, exp_mode);
      btn_mode_n = 1'b0;
      tick(10);
      btn_mode_n = 1'b1;
      tick(25);
      btn_up_n = 1'b1;
      tick(10);
      repeat (2) begin
         btn_up_n = 1'b0;
         tick(10);
         btn_up_n = 1'b1;
         tick(10);
      end
      drain(5);
      chk("run_after_cancel", select_mode, 0);

      // Simultaneous mode and up press: mode wins, no pulse.
      mode_press();
      exp_mode = exp_mode + 2'd1;
      push(0, cyc + LAT, exp_mode);
      btn_mode_n = 1'b0;
      btn_up_n = 1'b0;
      tick(10);
      btn_mode_n = 1'b1;
      btn_up_n = 1'b1;
      tick(10);
      repeat (2) mode_press();
      drain(20);

      // Blink cadence after entry to SET_HOUR, then idle behaviour.
      n = cyc;
      exp_mode = exp_mode + 2'd1;
      push(0, n + LAT, exp_mode);
      btn_mode_n = 1'b0;
      tick(10);
      btn_mode_n = 1'b1;
      r = cyc;
      e = n + LAT;
`ifdef TIME_SET_TIMEOUT_EN
      exp_mode = 2'd0;
      push(0, r + LAT + TO, 0);
`endif
      to_cyc(e + BH - 1);
      chk("blink_pre_toggle", blink_on, 1);
      to_cyc(e + BH);
      chk("blink_toggle1", blink_on, 0);
      to_cyc(e + 2 * BH - 1);
      chk("blink_hold_off", blink_on, 0);
      to_cyc(e + 2 * BH);
      chk("blink_toggle2", blink_on, 1);
      to_cyc(e + 3 * BH);
      chk("blink_toggle3", blink_on, 0);
`ifdef TIME_SET_TIMEOUT_EN
      to_cyc(r + LAT + TO - 1);
      chk("pre_timeout_mode", select_mode, 1);
      drain(10);
      chk("timeout_mode", select_mode, 0);
      chk("timeout_count_ena", count_ena, 1);
      chk("timeout_blink", blink_on, 1);
`else
      to_cyc(r + LAT + TO + 20);
      chk("no_timeout_mode", select_mode, 1);
      chk("no_timeout_count_ena", count_ena, 0);
      drain(5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Front-panel controller that sequences the clock's time counter. It debounces the mode/up/down pushbuttons and runs the mode state machine (RUN, SET_HOUR, SET_MIN, SET_SEC). It emits single-cycle increment/decrement pulses with hold-to-repeat, a count-enable that freezes timekeeping while setting, and a blink enable for the selected display field. It sits between the raw buttons and the counter/display datapath.

Parameters:
DB_CYCLES, 1_000_000, consecutive stable cycles to accept a button level change (20 ms at 50 MHz)
RPT_DELAY, 25_000_000, cycles from first pulse to first auto-repeat pulse while held
RPT_PERIOD, 10_000_000, cycles between subsequent auto-repeat pulses
BLINK_HALF, 12_500_000, cycles per blink half-period
TIMEOUT, 500_000_000, idle cycles in a SET state before auto-return to RUN (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_mode_n  in  1  raw mode button, active-low, asynchronous
btn_up_n  in  1  raw up button, active-low, asynchronous
btn_dw_n  in  1  raw down button, active-low, asynchronous
select_mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
inc_pulse  out  1  one-cycle increment of the selected field
dec_pulse  out  1  one-cycle decrement of the selected field
count_ena  out  1  1 = timekeeping runs; 0 = frozen
blink_on  out  1  1 = selected field visible; 0 = blanked

Behaviour:
- Reset (async assert, sync release): select_mode=00, inc_pulse=0, dec_pulse=0, count_ena=1, blink_on=1; synchronizers, debounced levels, repeat and blink counters cleared (buttons read as released).
- Input path per button: 2-FF synchronizer, then invert to active-high. Debounced level changes only after DB_CYCLES consecutive cycles in which the synchronized value differs from it. Any agreeing cycle restarts the count.
- Press event: one-cycle rising edge of the debounced level. Raw press to registered event/pulse latency is fixed at DB_CYCLES+3 cycles.
- Mode FSM: each mode press advances RUN->SET_HOUR->SET_MIN->SET_SEC->RUN. select_mode updates in the cycle after the event.
- count_ena = 1 in RUN, 0 in all SET states (registered, same cycle as select_mode).
- In RUN, up/down events produce no pulses and the repeat logic is held cleared.
- In SET states, up and down behave symmetrically:
  - A press issues a pulse in the cycle after the event.
  - While still held, the next pulse fires RPT_DELAY cycles after the first, then every RPT_PERIOD cycles.
  - Release stops repeating immediately.
- inc_pulse and dec_pulse are never high in the same cycle.
- Both up and down debounced-high: no pulses and repeat cleared. After one is released, the held one does not resume; a fresh press is required.
- Mode event while up/down is held: the state advances and repeat is cancelled. No further pulses until a fresh press, even in the new state.
- Simultaneous mode and up/down events in the same cycle: mode wins and no pulse is issued.
- Blink:
  - In RUN, blink_on=1.
  - On entry to a SET state, blink_on=1 and the counter restarts. blink_on then toggles every BLINK_HALF cycles.
  - Every inc/dec pulse forces blink_on=1 and restarts the counter, so the digit stays visible while adjusting.
- Counters saturate or are reset by their defined events; none wraps to produce a spurious pulse.
- Width of each counter is $clog2 of its parameter + 1.

Optional Feature:
- Macro: TIME_SET_TIMEOUT_EN.
- Defined: an idle counter runs in SET states and clears on any debounced button activity (edge or held level). When it reaches TIMEOUT, the FSM returns to RUN next cycle: count_ena=1, blink_on=1, repeat cleared.
- Undefined: no idle counter; SET states persist until mode presses return to RUN. The TIMEOUT parameter is ignored.

Decomposition:
- Package clock_pkg: mode typedef and constants MODE_RUN=2'b00, MODE_SET_HOUR=2'b01, MODE_SET_MIN=2'b10, MODE_SET_SEC=2'b11. The display and counter blocks share this encoding.
- One sub-module: btn_debounce (synchronizer + debounce + rising-edge output, parameter DB_CYCLES), instantiated three times.
- FSM, repeat, blink and timeout logic stay in time_set_ctrl.

Test Plan:
(Parameters DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8, BLINK_HALF=10, TIMEOUT=100, TIME_SET_TIMEOUT_EN defined.)
- Reset with buttons released -> select_mode=00, count_ena=1, blink_on=1, no pulses. Mode held low 3 cycles then released (bounce) -> no mode change.
- Four clean mode presses -> select_mode 01,10,11,00, each exactly 7 cycles after the raw falling edge. count_ena is 0 only during 01/10/11.
- In SET_MIN, up held 60 cycles -> inc_pulse at press+7, then +20, +28, +36 ... (6 pulses total). dec_pulse stays 0. blink_on stays 1 through each pulse.
- In SET_HOUR, up held, then down pressed and held -> pulses stop once both are debounced. Release up with down still held -> no pulses until down is re-pressed.
- In SET_SEC, mode pressed while up held -> select_mode=00, no pulse in or after the transition. Up presses in RUN -> no pulses.
- In SET_HOUR, idle 100 cycles -> select_mode=00, count_ena=1. With blink observed before that, blink_on toggles every 10 cycles after entry.
